// File: rtl/soc_system_edge_pio_pkg.sv
// Shared register map and event-counter constants for the edge-qualifying input PIO.
package soc_system_edge_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_EVCNT     = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE   = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN   = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN   = 3'd5;
  localparam logic [2:0] ADDR_DB_THRESH = 3'd6;

  localparam int                 EVCNT_W   = 16;
  localparam logic [EVCNT_W-1:0] EVCNT_SAT = '1;

  // An event in the same cycle as a clear leaves the count at 1, so it is never lost.
  function automatic logic [EVCNT_W-1:0] evcnt_next(input logic [EVCNT_W-1:0] cnt,
                                                    input logic clr,
                                                    input logic ev);
    if (ev) begin
      if (clr) return EVCNT_W'(1);
      return (cnt == EVCNT_SAT) ? cnt : cnt + EVCNT_W'(1);
    end
    return clr ? '0 : cnt;
  endfunction

endpackage

// File: rtl/soc_system_edge_pio_chan.sv
// One input channel: synchroniser, optional debounce (SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN), edge qualifier.
// ev is combinational from filt/filt_d and the enables; filt reaches the register file directly.
module soc_system_edge_pio_chan
  import soc_system_edge_pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
  ,
  parameter int DB_W = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_bit,
  input  logic            rise_en,
  input  logic            fall_en,
`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
  input  logic [DB_W-1:0] db_thresh,
`endif
  output logic            filt,
  output logic            ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt;
  logic [DB_W:0]   cnt_inc;
  logic            filt_q;

  assign cnt_inc = {1'b0, db_cnt} + (DB_W+1)'(1);

  // filt_q keeps tracking the synchroniser while the threshold is 0 so a later
  // non-zero threshold starts from a consistent filtered value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      db_cnt <= '0;
    end else if (db_thresh == '0) begin
      filt_q <= sync_out;
      db_cnt <= '0;
    end else if (sync_out == filt_q) begin
      db_cnt <= '0;
    end else if (cnt_inc >= {1'b0, db_thresh}) begin
      filt_q <= sync_out;
      db_cnt <= '0;
    end else begin
      db_cnt <= cnt_inc[DB_W-1:0];
    end
  end

  assign filt = (db_thresh == '0) ? sync_out : filt_q;
`else
  assign filt = sync_out;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) filt_d <= 1'b0;
    else       filt_d <= filt;
  end

  assign ev = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);

endmodule

// File: rtl/soc_system_edge_pio.sv
// Avalon-MM edge-capturing input PIO; debounce filter is built in with SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN.
// readdata is registered every cycle from the address mux; irq is a level from CAPTURE & IRQ_MASK.
module soc_system_edge_pio
  import soc_system_edge_pio_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16,
  parameter int DB_DEFAULT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DB_W < 1 || DB_W > 32 || DB_DEFAULT < 0) begin : g_param_check
    $error("soc_system_edge_pio: illegal parameter value");
  end

  logic               wr;
  logic [WIDTH-1:0]   filt;
  logic [WIDTH-1:0]   ev;
  logic [WIDTH-1:0]   irq_mask;
  logic [WIDTH-1:0]   capture;
  logic [WIDTH-1:0]   rise_en;
  logic [WIDTH-1:0]   fall_en;
  logic [WIDTH-1:0]   cap_clr;
  logic [EVCNT_W-1:0] evcnt;
  logic [31:0]        rd_mux;
  wire                unused_wdata = &{1'b0, writedata};

  assign wr      = chipselect & ~write_n;
  assign cap_clr = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] db_thresh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 db_thresh <= DB_W'(DB_DEFAULT);
    else if (wr && address == ADDR_DB_THRESH)  db_thresh <= writedata[DB_W-1:0];
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    soc_system_edge_pio_chan #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
      ,
      .DB_W        (DB_W)
`endif
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (in_port[i]),
      .rise_en   (rise_en[i]),
      .fall_en   (fall_en[i]),
`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
      .db_thresh (db_thresh),
`endif
      .filt      (filt[i]),
      .ev        (ev[i])
    );
  end

  // Set beats clear on CAPTURE so a coincident event is never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      capture  <= '0;
      rise_en  <= '1;
      fall_en  <= '1;
      evcnt    <= '0;
    end else begin
      capture <= (capture & ~cap_clr) | ev;
      evcnt   <= evcnt_next(evcnt, wr && address == ADDR_EVCNT, |ev);
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_RISE_EN)  rise_en  <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_FALL_EN)  fall_en  <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:      rd_mux[WIDTH-1:0]   = filt;
      ADDR_EVCNT:     rd_mux[EVCNT_W-1:0] = evcnt;
      ADDR_IRQ_MASK:  rd_mux[WIDTH-1:0]   = irq_mask;
      ADDR_CAPTURE:   rd_mux[WIDTH-1:0]   = capture;
      ADDR_RISE_EN:   rd_mux[WIDTH-1:0]   = rise_en;
      ADDR_FALL_EN:   rd_mux[WIDTH-1:0]   = fall_en;
`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
      ADDR_DB_THRESH: rd_mux[DB_W-1:0]    = db_thresh;
`endif
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(capture & irq_mask);

endmodule

// File: tb/tb_soc_system_edge_pio.sv
// Directed bench for soc_system_edge_pio: register table plus edge, clear/set, saturation, debounce, reset sequences.
module tb_soc_system_edge_pio;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  soc_system_edge_pio #(.WIDTH(W), .SYNC_STAGES(2), .DB_W(16), .DB_DEFAULT(1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
  localparam logic [31:0] THRESH_RST = 32'd1000;
`else
  localparam logic [31:0] THRESH_RST = 32'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  // New input value, then a register write landing on the edge where the event is captured.
  task automatic edge_with_write(input logic [W-1:0] newin, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); in_port = newin;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  vec_t vecs[15];
  logic [31:0] d;

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{3'd3, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{3'd1, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{3'd4, 1'b0, 32'h0, 32'hF};
    vecs[4]  = '{3'd5, 1'b0, 32'h0, 32'hF};
    vecs[5]  = '{3'd2, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{3'd7, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{3'd6, 1'b0, 32'h0, THRESH_RST};
    vecs[8]  = '{3'd6, 1'b1, 32'h0, 32'h0};
    vecs[9]  = '{3'd2, 1'b1, 32'hFFFF_FFFF, 32'hF};
    vecs[10] = '{3'd4, 1'b1, 32'h1, 32'h1};
    vecs[11] = '{3'd5, 1'b1, 32'h0, 32'h0};
    vecs[12] = '{3'd2, 1'b1, 32'h1, 32'h1};
    vecs[13] = '{3'd0, 1'b1, 32'hF, 32'h0};
    vecs[14] = '{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0};

    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
    end
    chk("irq_idle", {31'b0, irq}, 32'h0);

    // Rising edge on ch0: irq exactly 3 cycles after the input change.
    @(negedge clk); address = 3'd3; in_port[0] = 1'b1;
    @(posedge clk); #1 chk("rise_irq_c1", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 chk("rise_irq_c2", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 chk("rise_irq_c3", {31'b0, irq}, 32'h1);
    @(negedge clk); in_port[0] = 1'b0;
    repeat (5) @(posedge clk);
    rd(3'd3, d); chk("rise_capture", d, 32'h1);
    rd(3'd1, d); chk("rise_evcnt", d, 32'h1);
    wr(3'd3, 32'h1);
    chk("clear_irq", {31'b0, irq}, 32'h0);

    wr(3'd4, 32'hF);
    wr(3'd5, 32'hF);
    edge_with_write(4'b0010, 3'd3, 32'h2);
    rd(3'd3, d); chk("clr_vs_set_capture", d, 32'h2);
    rd(3'd1, d); chk("evcnt_after_ch1", d, 32'h2);
    edge_with_write(4'b0000, 3'd1, 32'h0);
    rd(3'd1, d); chk("clr_vs_ev_evcnt", d, 32'h1);

    @(negedge clk); in_port = 4'hF;
    repeat (5) @(posedge clk);
    rd(3'd1, d); chk("simul_evcnt", d, 32'h2);
    rd(3'd3, d); chk("simul_capture", d, 32'hF);
    chk("simul_irq", {31'b0, irq}, 32'h1);

    for (int i = 0; i < 70000; i++) begin
      @(negedge clk); in_port[0] = ~in_port[0];
    end
    repeat (5) @(posedge clk);
    rd(3'd1, d); chk("evcnt_saturate", d, 32'h0000_FFFF);
    @(negedge clk); in_port = '0;
    repeat (5) @(posedge clk);
    rd(3'd1, d); chk("evcnt_hold_sat", d, 32'h0000_FFFF);
    wr(3'd1, 32'h0);
    rd(3'd1, d); chk("evcnt_clear", d, 32'h0);
    wr(3'd3, 32'hF);
    rd(3'd3, d); chk("capture_w1c_all", d, 32'h0);

`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
    wr(3'd6, 32'd8);
    rd(3'd6, d); chk("db_thresh_rw", d, 32'd8);
    @(negedge clk); in_port[0] = 1'b1;
    repeat (5) @(negedge clk);
    in_port[0] = 1'b0;
    repeat (20) @(posedge clk);
    rd(3'd3, d); chk("glitch_capture", d, 32'h0);
    rd(3'd0, d); chk("glitch_data", d, 32'h0);
    @(negedge clk); address = 3'd0; in_port[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 10) chk("db_data_pre", readdata, 32'h0);
      if (k == 11) chk("db_data_set", readdata, 32'h1);
    end
    repeat (20) @(posedge clk);
    rd(3'd3, d); chk("db_capture", d, 32'h1);
    rd(3'd1, d); chk("db_evcnt", d, 32'h1);
    wr(3'd6, 32'd0);
`endif

    wr(3'd1, 32'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); in_port = in_port ^ 4'hF;
      repeat (3) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    rd(3'd1, d); chk("pre_rst_evcnt", d, 32'd9);
    rd(3'd3, d); chk("pre_rst_capture", d, 32'hF);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);

    @(negedge clk); address = 3'd1; reset = 1'b1;
    #1;
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    in_port = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    rd(3'd0, d); chk("post_rst_data", d, 32'h0);
    rd(3'd1, d); chk("post_rst_evcnt", d, 32'h0);
    rd(3'd2, d); chk("post_rst_mask", d, 32'h0);
    rd(3'd3, d); chk("post_rst_capture", d, 32'h0);
    rd(3'd4, d); chk("post_rst_rise_en", d, 32'hF);
    rd(3'd5, d); chk("post_rst_fall_en", d, 32'hF);
    rd(3'd6, d); chk("post_rst_thresh", d, THRESH_RST);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
